move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of WAIT cycles granted to one character per step.
REQ-002 Parameter NUM_CHARS, default 4, is the number of character controllers sequenced; index 0 is Pacman, indices 1-3 are ghosts.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clock in 1, rising-edge clock; reset in 1, active-low synchronous reset.
REQ-004 tick  in  1  one-cycle pulse that starts a game step.
REQ-005 char_active  in  4  per-character participate mask, sampled in SELECT.
REQ-006 char_done  in  4  per-character move-complete pulse.
REQ-007 char_map_write  in  4  per-character map write request.
REQ-008 char_map_addr  in  36  per-character 9-bit map address; character i occupies bits [9i+8:9i].
REQ-009 char_sprite  in  12  per-character 3-bit sprite code; character i occupies bits [3i+2:3i].
REQ-010 char_enable  out  4  one-hot, one-cycle move enable.
REQ-011 map_address_write  out  9  map RAM write address.
REQ-012 sprite_data_out  out  3  map RAM write data.
REQ-013 map_write  out  1  map RAM write strobe.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 cur_char  out  2  index of the character being serviced.
REQ-016 step_done  out  1  one-cycle pulse at the end of a step.
REQ-017 timeout_err  out  1  sticky flag: a character missed its TIMEOUT.
REQ-018 tick_overrun  out  1  sticky flag: tick arrived while busy.

Function
REQ-019 States SHALL be IDLE, SELECT, ENABLE, WAIT, ADVANCE and FINISH; char_enable, busy and step_done SHALL be decoded from state only.
REQ-020 IDLE: on tick=1 the block SHALL load idx=0 and enter SELECT; otherwise it SHALL remain in IDLE.
REQ-021 SELECT (one cycle): char_active[idx]=1 SHALL lead to ENABLE; otherwise to ADVANCE.
REQ-022 ENABLE (one cycle): char_enable[idx]=1 and all other char_enable bits 0; the wait timer SHALL be cleared; next state WAIT.
REQ-023 WAIT: char_done[idx]=1 SHALL lead to ADVANCE; the timer reaching TIMEOUT-1 without done SHALL set timeout_err and lead to ADVANCE; done and timeout in the same cycle count as done.
REQ-024 ADVANCE (one cycle): idx=NUM_CHARS-1 SHALL lead to FINISH; otherwise idx increments and the next state is SELECT.
REQ-025 FINISH (one cycle): step_done=1; next state IDLE.
REQ-026 Write forwarding applies in WAIT only: char_map_write[idx]=1 SHALL register the idx slice of address and sprite and assert map_write for exactly one cycle on the next cycle (1-cycle latency).
REQ-027 Write requests from non-selected characters, and any request outside WAIT, SHALL be dropped with no effect.
REQ-028 A write and done in the same WAIT cycle SHALL still forward the write.
REQ-029 tick while busy=1 SHALL be ignored and SHALL set tick_overrun; a tick sampled in FINISH also counts as overrun.
REQ-030 cur_char SHALL equal idx in every state and 0 in IDLE.
REQ-031 Latency with all characters inactive: tick sampled at edge E0 -> step_done high during the 9th cycle after E0.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, idx=0 and timer=0, and drive every output to 0, including clearing both sticky flags; this applies mid-step as well.
REQ-033 A forwarded write pending at reset SHALL be dropped, so map_write=0 in the cycle after reset.

Structure
REQ-034 The shared package SHALL hold the state enum, NUM_CHARS=4, MAP_ADDR_W=9, SPRITE_W=3 and MAP_WIDTH=21.
REQ-035 The block SHALL use one sub-module, wait_timer: a clear/enable counter with a terminal-count output at TIMEOUT-1.

Verification
REQ-036 char_active=0000, tick pulse -> char_enable never asserts, map_write=0, step_done pulse 9 cycles after tick, busy=0 afterward.
REQ-037 char_active=0001, char 0 requests a write to addr 9'd44 with sprite 3'b000 in its 2nd WAIT cycle, then done -> map_write pulses one cycle later with address_write=44 and sprite_data_out=0; char_enable=0001 appears exactly once.
REQ-038 char_active=0011, char 1 never asserts done -> WAIT lasts 64 cycles, timeout_err=1, and step_done still pulses.
REQ-039 char 2 is selected while char 0 requests a write to addr 9'd5 -> no map_write occurs.
REQ-040 tick re-pulsed mid-step, then reset=0 mid-WAIT -> tick_overrun=1 before reset; after reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// move_scheduler_pkg
//   Shared definitions for the move scheduler: the sequencer state encoding,
//   bus geometry constants and helpers that pick one character's slice out of
//   the packed per-character address and sprite buses.
package move_scheduler_pkg;

  localparam int NUM_CHARS  = 4;
  localparam int MAP_ADDR_W = 9;
  localparam int SPRITE_W   = 3;
  localparam int MAP_WIDTH  = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ENABLE,
    ST_WAIT,
    ST_ADVANCE,
    ST_FINISH
  } state_e;

  // Character i owns bits [9i+8:9i] of the packed address bus.
  function automatic logic [MAP_ADDR_W-1:0] addr_slice(
    input logic [NUM_CHARS*MAP_ADDR_W-1:0] addr_bus,
    input logic [1:0]                      idx
  );
    return addr_bus[idx*MAP_ADDR_W +: MAP_ADDR_W];
  endfunction

  // Character i owns bits [3i+2:3i] of the packed sprite bus.
  function automatic logic [SPRITE_W-1:0] sprite_slice(
    input logic [NUM_CHARS*SPRITE_W-1:0] sprite_bus,
    input logic [1:0]                    idx
  );
    return sprite_bus[idx*SPRITE_W +: SPRITE_W];
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// move_scheduler_if
//   Bundles the character-controller side (participation mask, done pulses,
//   map write requests, one-hot move enable) and the map RAM write port.
//   slave  : the scheduler (consumes character requests, drives enable/map)
//   master : the character controllers / map RAM side
interface move_scheduler_if;
  import move_scheduler_pkg::*;

  logic [NUM_CHARS-1:0]            char_active;
  logic [NUM_CHARS-1:0]            char_done;
  logic [NUM_CHARS-1:0]            char_map_write;
  logic [NUM_CHARS*MAP_ADDR_W-1:0] char_map_addr;
  logic [NUM_CHARS*SPRITE_W-1:0]   char_sprite;
  logic [NUM_CHARS-1:0]            char_enable;
  logic [MAP_ADDR_W-1:0]           map_address_write;
  logic [SPRITE_W-1:0]             sprite_data_out;
  logic                            map_write;

  modport slave (
    input  char_active, char_done, char_map_write, char_map_addr, char_sprite,
    output char_enable, map_address_write, sprite_data_out, map_write
  );

  modport master (
    output char_active, char_done, char_map_write, char_map_addr, char_sprite,
    input  char_enable, map_address_write, sprite_data_out, map_write
  );

endinterface

// File: rtl/move_scheduler_wait_timer.sv
// wait_timer
//   Cycle counter bounding how long one character may stay in WAIT.
//   clock, reset (active-low, synchronous)
//   clear    : zero the count (takes priority over enable)
//   enable   : advance the count by one
//   terminal : count has reached TIMEOUT-1; the count holds there
module wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign terminal = (count_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler
//   On each game tick, visits characters 0..NUM_CHARS-1 in order. Active ones
//   get a one-cycle move enable and are then waited on (up to TIMEOUT cycles)
//   for a done pulse; map writes from the character being waited on are
//   forwarded to the map RAM with one cycle of latency.
//   clock, reset (active-low, synchronous)
//   tick         : one-cycle pulse starting a step
//   bus          : character/map interface (slave side)
//   busy         : high whenever not IDLE
//   cur_char     : index of the character being serviced
//   step_done    : one-cycle pulse at the end of a step
//   timeout_err  : sticky, a character failed to finish in time
//   tick_overrun : sticky, a tick arrived while a step was in progress
module move_scheduler #(
  parameter int TIMEOUT   = 64,
  parameter int NUM_CHARS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  move_scheduler_if.slave        bus,
  output logic                   busy,
  output logic [1:0]             cur_char,
  output logic                   step_done,
  output logic                   timeout_err,
  output logic                   tick_overrun
);
  import move_scheduler_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(NUM_CHARS - 1);

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  tick_overrun_q, tick_overrun_d;
  logic                  map_write_q, map_write_d;
  logic [MAP_ADDR_W-1:0] map_addr_q, map_addr_d;
  logic [SPRITE_W-1:0]   sprite_q, sprite_d;
  logic                  timer_clear, timer_en, timer_tc;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timer_tc)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    timer_clear    = 1'b0;
    timer_en       = 1'b0;
    timeout_err_d  = timeout_err_q;
    // Any tick outside IDLE (FINISH included) is dropped but remembered.
    tick_overrun_d = tick_overrun_q | (tick && (state_q != ST_IDLE));
    map_write_d    = 1'b0;
    map_addr_d     = map_addr_q;
    sprite_d       = sprite_q;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        state_d = bus.char_active[idx_q] ? ST_ENABLE : ST_ADVANCE;
      end
      ST_ENABLE: begin
        timer_clear = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        // Only the character being waited on may reach the map.
        if (bus.char_map_write[idx_q]) begin
          map_write_d = 1'b1;
          map_addr_d  = addr_slice(bus.char_map_addr, idx_q);
          sprite_d    = sprite_slice(bus.char_sprite, idx_q);
        end
        // Done wins over a simultaneous timeout.
        if (bus.char_done[idx_q]) begin
          state_d = ST_ADVANCE;
        end else if (timer_tc) begin
          timeout_err_d = 1'b1;
          state_d       = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SELECT;
        end
      end
      ST_FINISH: begin
        // Clearing idx here keeps cur_char at 0 while idle.
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      timeout_err_q  <= 1'b0;
      tick_overrun_q <= 1'b0;
      map_write_q    <= 1'b0;
      map_addr_q     <= '0;
      sprite_q       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      timeout_err_q  <= timeout_err_d;
      tick_overrun_q <= tick_overrun_d;
      map_write_q    <= map_write_d;
      map_addr_q     <= map_addr_d;
      sprite_q       <= sprite_d;
    end
  end

  assign bus.char_enable       = (state_q == ST_ENABLE) ? (4'b0001 << idx_q) : 4'b0000;
  assign bus.map_write         = map_write_q;
  assign bus.map_address_write = map_addr_q;
  assign bus.sprite_data_out   = sprite_q;
  assign busy                  = (state_q != ST_IDLE);
  assign step_done             = (state_q == ST_FINISH);
  assign cur_char              = idx_q;
  assign timeout_err           = timeout_err_q;
  assign tick_overrun          = tick_overrun_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler
//   Directed bench for move_scheduler. Inputs change and outputs are sampled
//   on the falling clock edge; cycle numbers count falling edges after the
//   one at which tick was raised.
module tb_move_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       busy;
  logic [1:0] cur_char;
  logic       step_done;
  logic       timeout_err;
  logic       tick_overrun;

  int checks;
  int failures;

  int         cycleNum;
  int         enableCount;
  logic [3:0] enableLast;
  int         mapWriteCount;
  int         stepDoneCount;
  int         stepDoneCycle;

  localparam logic [35:0] ADDR_BUS_44  = {9'd300, 9'd200, 9'd100, 9'd44};
  localparam logic [35:0] ADDR_BUS_5   = {9'd300, 9'd200, 9'd100, 9'd5};
  localparam logic [11:0] SPRITE_BUS   = {3'd7, 3'd6, 3'd5, 3'd0};

  move_scheduler_if bus_if ();

  move_scheduler #(
    .TIMEOUT   (64),
    .NUM_CHARS (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .bus          (bus_if.slave),
    .busy         (busy),
    .cur_char     (cur_char),
    .step_done    (step_done),
    .timeout_err  (timeout_err),
    .tick_overrun (tick_overrun)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] active, input logic [3:0] done,
                               input logic [3:0] wr, input logic [35:0] addr,
                               input logic [11:0] sprite);
    bus_if.char_active    = active;
    bus_if.char_done      = done;
    bus_if.char_map_write = wr;
    bus_if.char_map_addr  = addr;
    bus_if.char_sprite    = sprite;
  endtask

  // Advance to the next falling edge and tally observed events.
  task automatic waitCycle();
    @(negedge clock);
    cycleNum++;
    if (bus_if.char_enable != 4'b0000) begin
      enableCount++;
      enableLast = bus_if.char_enable;
    end
    if (bus_if.map_write) mapWriteCount++;
    if (step_done) begin
      stepDoneCount++;
      stepDoneCycle = cycleNum;
    end
  endtask

  task automatic startStep();
    cycleNum      = 0;
    enableCount   = 0;
    enableLast    = 4'b0000;
    mapWriteCount = 0;
    stepDoneCount = 0;
    stepDoneCycle = 0;
    tick = 1'b1;
    waitCycle();
    tick = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    tick     = 1'b0;
    cycleNum = 0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, ADDR_BUS_44, SPRITE_BUS);
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_enable", bus_if.char_enable, 0);
    checkOutput("rst_map_write", bus_if.map_write, 0);
    checkOutput("rst_flags", {timeout_err, tick_overrun, step_done}, 0);
    reset = 1'b1;
    @(negedge clock);

    // All characters inactive.
    startStep();
    while (cycleNum < 12) begin
      waitCycle();
      if (cycleNum == 5) checkOutput("A_busy_mid", busy, 1);
    end
    checkOutput("A_step_cycle", stepDoneCycle, 9);
    checkOutput("A_step_count", stepDoneCount, 1);
    checkOutput("A_enable_count", enableCount, 0);
    checkOutput("A_map_writes", mapWriteCount, 0);
    checkOutput("A_busy_after", busy, 0);
    checkOutput("A_cur_char_idle", cur_char, 0);

    // Character 0 writes addr 44 in its 2nd WAIT cycle, then finishes.
    applyStimulus(4'b0001, 4'b0000, 4'b0000, ADDR_BUS_44, SPRITE_BUS);
    startStep();
    while (cycleNum < 16) begin
      waitCycle();
      case (cycleNum)
        2: checkOutput("B_enable", bus_if.char_enable, 4'b0001);
        4: begin
          checkOutput("B_no_early_write", bus_if.map_write, 0);
          bus_if.char_map_write = 4'b0001;
        end
        5: begin
          checkOutput("B_map_write", bus_if.map_write, 1);
          checkOutput("B_addr", bus_if.map_address_write, 44);
          checkOutput("B_sprite", bus_if.sprite_data_out, 0);
          bus_if.char_map_write = 4'b0000;
          bus_if.char_done      = 4'b0001;
        end
        6: begin
          checkOutput("B_write_once", bus_if.map_write, 0);
          bus_if.char_done = 4'b0000;
        end
        default: ;
      endcase
    end
    checkOutput("B_enable_count", enableCount, 1);
    checkOutput("B_map_writes", mapWriteCount, 1);
    checkOutput("B_step_cycle", stepDoneCycle, 13);

    // Character 1 never finishes: 64 WAIT cycles then timeout.
    applyStimulus(4'b0011, 4'b0000, 4'b0000, ADDR_BUS_44, SPRITE_BUS);
    startStep();
    while (cycleNum < 80) begin
      waitCycle();
      case (cycleNum)
        3: bus_if.char_done = 4'b0001;
        4: bus_if.char_done = 4'b0000;
        6: checkOutput("C_enable1", bus_if.char_enable, 4'b0010);
        70: begin
          checkOutput("C_no_err_yet", timeout_err, 0);
          checkOutput("C_busy_wait", busy, 1);
        end
        71: begin
          checkOutput("C_err_set", timeout_err, 1);
          checkOutput("C_cur_char", cur_char, 1);
        end
        default: ;
      endcase
    end
    checkOutput("C_step_cycle", stepDoneCycle, 76);
    checkOutput("C_enable_count", enableCount, 2);
    checkOutput("C_busy_after", busy, 0);

    // Character 2 serviced while character 0 keeps requesting writes.
    applyStimulus(4'b0100, 4'b0000, 4'b0001, ADDR_BUS_5, SPRITE_BUS);
    startStep();
    while (cycleNum < 15) begin
      waitCycle();
      case (cycleNum)
        6: begin
          checkOutput("D_cur_char", cur_char, 2);
          checkOutput("D_enable2", bus_if.char_enable, 4'b0100);
        end
        8: bus_if.char_done = 4'b0100;
        9: bus_if.char_done = 4'b0000;
        default: ;
      endcase
    end
    checkOutput("D_map_writes", mapWriteCount, 0);
    checkOutput("D_step_cycle", stepDoneCycle, 12);
    checkOutput("D_err_sticky", timeout_err, 1);

    // Tick overrun mid-WAIT, then reset together with a pending write.
    applyStimulus(4'b0001, 4'b0000, 4'b0000, ADDR_BUS_44, SPRITE_BUS);
    startStep();
    waitCycle();
    waitCycle();
    checkOutput("E_overrun_pre", tick_overrun, 0);
    waitCycle();
    tick = 1'b1;
    waitCycle();
    tick = 1'b0;
    checkOutput("E_overrun_set", tick_overrun, 1);
    checkOutput("E_still_char0", {busy, cur_char}, 3'b100);
    bus_if.char_map_write = 4'b0001;
    reset = 1'b0;
    waitCycle();
    checkOutput("E_rst_map_write", bus_if.map_write, 0);
    checkOutput("E_rst_addr", bus_if.map_address_write, 0);
    checkOutput("E_rst_busy", busy, 0);
    checkOutput("E_rst_cur_char", cur_char, 0);
    checkOutput("E_rst_flags", {timeout_err, tick_overrun, step_done}, 0);
    checkOutput("E_rst_enable", bus_if.char_enable, 0);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, ADDR_BUS_44, SPRITE_BUS);
    waitCycle();
    waitCycle();
    checkOutput("E_idle_busy", busy, 0);
    checkOutput("E_idle_map_write", bus_if.map_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
